// File: rtl/id_ex_fwd_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_reg_pkg
//   Shared constants for the ID/EX pipeline register and its forwarding logic.
//   The FWD_* values are the select encodings seen by the EX-stage operand
//   MUX_4to1 instances:
//     FWD_REG   - value read from the register file in ID
//     FWD_EXMEM - result forwarded from the EX/MEM register
//     FWD_MEMWB - result forwarded from the MEM/WB register
//     FWD_IMM   - immediate (ALU operand B only)
// ---------------------------------------------------------------------------
package id_ex_fwd_reg_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_IMM   = 2'b11;

endpackage : id_ex_fwd_reg_pkg

// File: rtl/id_ex_fwd_reg_fwd_sel_calc.sv
// ---------------------------------------------------------------------------
// fwd_sel_calc
//   Combinational forwarding-select calculator for one source operand.
//   The select is computed while the instruction is still in ID and is
//   registered with it, so "EX stage now" becomes "EX/MEM next cycle" and
//   "EX/MEM now" becomes "MEM/WB next cycle".
//
//   src_idx      in  source register index of the ID-stage instruction
//   src_used     in  instruction actually reads this operand
//   ex_valid     in  instruction currently in EX is real
//   ex_regwrite  in  instruction currently in EX writes ex_rd
//   ex_rd        in  destination of the instruction currently in EX
//   mem_regwrite in  instruction currently in EX/MEM writes mem_rd
//   mem_rd       in  destination of the instruction currently in EX/MEM
//   sel          out FWD_REG / FWD_EXMEM / FWD_MEMWB
// ---------------------------------------------------------------------------
module fwd_sel_calc
  import id_ex_fwd_reg_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_idx,
  input  logic              src_used,
  input  logic              ex_valid,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  output logic [1:0]        sel
);

  always_comb begin
    // NOTE: default assignment first so every path drives sel (no latch).
    sel = FWD_REG;
    // $0 is hard-wired zero and is never forwarded. The younger producer
    // (EX) wins over the older one (EX/MEM) when both match.
    if (src_used && (src_idx != '0)) begin
      if (ex_valid && ex_regwrite && (ex_rd == src_idx)) begin
        sel = FWD_EXMEM;
      end else if (mem_regwrite && (mem_rd == src_idx)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule : fwd_sel_calc

// File: rtl/id_ex_fwd_reg.sv
// ---------------------------------------------------------------------------
// id_ex_fwd_reg
//   ID/EX pipeline register of the 5-stage CPU. Captures decoded operands and
//   control, pre-computes the registered forwarding selects for the EX operand
//   muxes, and detects load-use hazards (inserting one bubble for each).
//
//   Ports
//     clk_i, rst_i (async, active-low)
//     stall_i         hold every register
//     flush_i         load a bubble (beats stall_i)
//     id_*            decoded ID-stage instruction
//     mem_rd_i, mem_regwrite_i   destination/write-enable currently in EX/MEM
//     ex_*            registered instruction fields for EX
//     ex_fwd_a_o      ALU-A select (00 reg, 01 EX/MEM, 10 MEM/WB)
//     ex_fwd_rt_o     store-data select, same encoding
//     ex_fwd_b_o      ALU-B select (11 = immediate, else ex_fwd_rt_o)
//     load_use_stall_o combinational: hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_ex_fwd_reg
  import id_ex_fwd_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_use_rt_i,
  input  logic              id_alusrc_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_regwrite_i,
  output logic              ex_valid_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_regwrite_o,
  output logic              ex_memread_o,
  output logic [1:0]        ex_fwd_a_o,
  output logic [1:0]        ex_fwd_rt_o,
  output logic [1:0]        ex_fwd_b_o,
  output logic              load_use_stall_o
);

  logic [1:0] fwd_a_next;
  logic [1:0] fwd_rt_next;
  logic [1:0] fwd_b_next;
  logic       hold;
  logic       load_bubble;

  fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_rs (
    .src_idx      (id_rs_i),
    .src_used     (1'b1),
    .ex_valid     (ex_valid_o),
    .ex_regwrite  (ex_regwrite_o),
    .ex_rd        (ex_rd_o),
    .mem_regwrite (mem_regwrite_i),
    .mem_rd       (mem_rd_i),
    .sel          (fwd_a_next)
  );

  fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_rt (
    .src_idx      (id_rt_i),
    .src_used     (id_use_rt_i),
    .ex_valid     (ex_valid_o),
    .ex_regwrite  (ex_regwrite_o),
    .ex_rd        (ex_rd_o),
    .mem_regwrite (mem_regwrite_i),
    .mem_rd       (mem_rd_i),
    .sel          (fwd_rt_next)
  );

  assign fwd_b_next = id_alusrc_i ? FWD_IMM : fwd_rt_next;

  // A load in EX whose result a real ID instruction needs: its data only
  // exists after MEM, so the consumer waits one cycle and then picks it up
  // from MEM/WB.
  assign load_use_stall_o = ex_valid_o && ex_memread_o && (ex_rd_o != '0) &&
                            id_valid_i &&
                            ((ex_rd_o == id_rs_i) ||
                             (id_use_rt_i && (ex_rd_o == id_rt_i)));

  // Priority: flush > stall > load-use bubble > normal load.
  assign hold        = stall_i && !flush_i;
  assign load_bubble = flush_i || load_use_stall_o || !id_valid_i;

  // NOTE: sequential state uses non-blocking assignments only; the async
  // reset clears every register, including the wide data fields, so a
  // bubble is fully defined out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_ctrl_o     <= '0;
      ex_rs_data_o  <= '0;
      ex_rt_data_o  <= '0;
      ex_imm_o      <= '0;
      ex_rd_o       <= '0;
      ex_regwrite_o <= 1'b0;
      ex_memread_o  <= 1'b0;
      ex_fwd_a_o    <= FWD_REG;
      ex_fwd_rt_o   <= FWD_REG;
      ex_fwd_b_o    <= FWD_REG;
    end else if (!hold) begin
      if (load_bubble) begin
        ex_valid_o    <= 1'b0;
        ex_ctrl_o     <= '0;
        ex_rs_data_o  <= '0;
        ex_rt_data_o  <= '0;
        ex_imm_o      <= '0;
        ex_rd_o       <= '0;
        ex_regwrite_o <= 1'b0;
        ex_memread_o  <= 1'b0;
        ex_fwd_a_o    <= FWD_REG;
        ex_fwd_rt_o   <= FWD_REG;
        ex_fwd_b_o    <= FWD_REG;
      end else begin
        ex_valid_o    <= 1'b1;
        ex_ctrl_o     <= id_ctrl_i;
        ex_rs_data_o  <= id_rs_data_i;
        ex_rt_data_o  <= id_rt_data_i;
        ex_imm_o      <= id_imm_i;
        ex_rd_o       <= id_rd_i;
        ex_regwrite_o <= id_regwrite_i;
        ex_memread_o  <= id_memread_i;
        ex_fwd_a_o    <= fwd_a_next;
        ex_fwd_rt_o   <= fwd_rt_next;
        ex_fwd_b_o    <= fwd_b_next;
      end
    end
  end

endmodule : id_ex_fwd_reg
